// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU opcode decode, EX-stage forwarding,
// stall hold and flush bubble.
module id_ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [1:0]   alu_op_in,
    input  logic [5:0]   funct_in,
    input  logic [W-1:0] rs_data_in,
    input  logic [W-1:0] rt_data_in,
    input  logic [W-1:0] imm_in,
    input  logic [4:0]   rs_in,
    input  logic [4:0]   rt_in,
    input  logic [4:0]   rd_in,
    input  logic         alu_src_in,
    input  logic         reg_dst_in,
    input  logic         reg_write_in,
    input  logic         mem_read_in,
    input  logic         mem_write_in,
    input  logic         mem_to_reg_in,
    input  logic         exmem_reg_write,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_result,
    output logic [4:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [W-1:0] store_data,
    output logic [4:0]   dest,
    output logic         valid_out,
    output logic         reg_write_out,
    output logic         mem_read_out,
    output logic         mem_write_out,
    output logic         mem_to_reg_out,
    output logic         illegal
);
    logic [W-1:0] rs_data_q, rt_data_q, imm_q, fwd_rs, fwd_rt;
    logic [4:0]   rs_q, rt_q, r_op, dec_op;
    logic         alu_src_q, r_bad, dec_bad, kill;

    always_comb begin
        r_op = funct_in == 6'b100000 ? 5'b00001 :
               funct_in == 6'b100010 ? 5'b00010 :
               funct_in == 6'b100100 ? 5'b00100 :
               funct_in == 6'b100101 ? 5'b10000 :
               funct_in == 6'b101010 ? 5'b01000 : 5'b00001;
        r_bad = !(funct_in inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
        dec_op = alu_op_in == 2'b00 ? 5'b00001 :
                 alu_op_in == 2'b01 ? 5'b00010 :
                 alu_op_in == 2'b11 ? 5'b01000 : r_op;
        dec_bad = valid_in && alu_op_in == 2'b10 && r_bad;
        kill = !valid_in || dec_bad;
    end

    // EX/MEM has the newer result, so it is checked first; register 0 never forwards
    assign fwd_rs = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs_q) ? exmem_result :
                    (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs_q) ? memwb_result : rs_data_q;
    assign fwd_rt = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rt_q) ? exmem_result :
                    (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rt_q) ? memwb_result : rt_data_q;

    assign alu_a      = fwd_rs;
    assign store_data = fwd_rt;
    assign alu_b      = alu_src_q ? imm_q : fwd_rt;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            alu_op         <= 5'b00001;
            rs_data_q      <= '0;
            rt_data_q      <= '0;
            imm_q          <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            dest           <= '0;
            alu_src_q      <= 1'b0;
            valid_out      <= 1'b0;
            reg_write_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            illegal        <= 1'b0;
        end else if (!stall) begin
            alu_op         <= dec_op;
            rs_data_q      <= rs_data_in;
            rt_data_q      <= rt_data_in;
            imm_q          <= imm_in;
            rs_q           <= rs_in;
            rt_q           <= rt_in;
            dest           <= reg_dst_in ? rd_in : rt_in;
            alu_src_q      <= alu_src_in;
            valid_out      <= valid_in;
            reg_write_out  <= reg_write_in && !kill;
            mem_read_out   <= mem_read_in && !kill;
            mem_write_out  <= mem_write_in && !kill;
            mem_to_reg_out <= mem_to_reg_in && valid_in;
            illegal        <= dec_bad;
        end
    end
endmodule
